// File: rtl/sim_run_ctrl.sv
// Run controller for the single-cycle MIPS harness: stretches the core reset, counts RUN cycles
// and ends the run on a halt instruction, a PC self-loop or a cycle-limit timeout.
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned STALL_LIMIT  = 4,
    parameter bit          HALT_EN      = 1'b1,
    parameter logic [31:0] HALT_INSTR   = 32'h0000_000C,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [31:0]      final_pc
);

    localparam int unsigned HoldW  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

    localparam logic [HoldW-1:0]  HoldLast = HoldW'(RESET_CYCLES - 1);
    localparam logic [StallW-1:0] StallHit = StallW'(STALL_LIMIT - 2);
    localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(MAX_CYCLES - 1);

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseHalt  = 2'b01;
    localparam logic [1:0] CauseLoop  = 2'b10;
    localparam logic [1:0] CauseLimit = 2'b11;

    typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [StallW-1:0]  stall_q, stall_d;
    logic [31:0]        prev_pc_q, prev_pc_d;
    logic               prev_valid_q, prev_valid_d;
    logic               core_reset_q, core_reset_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        final_pc_q, final_pc_d;

    logic               same_pc;
    logic [1:0]         hit_cause;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHold;
            hold_q       <= '0;
            stall_q      <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            cause_q      <= CauseNone;
            cnt_q        <= '0;
            final_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            stall_q      <= stall_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            cause_q      <= cause_d;
            cnt_q        <= cnt_d;
            final_pc_q   <= final_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        stall_d      = stall_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        core_reset_d = core_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        cause_d      = cause_q;
        cnt_d        = cnt_q;
        final_pc_d   = final_pc_q;

        same_pc   = prev_valid_q && (pc == prev_pc_q);
        // Fixed priority: halt instruction, then self-loop, then timeout.
        hit_cause = CauseNone;
        if (HALT_EN && (instr == HALT_INSTR)) begin
            hit_cause = CauseHalt;
        end else if (same_pc && (stall_q == StallHit)) begin
            hit_cause = CauseLoop;
        end else if (cnt_q == CntLast) begin
            hit_cause = CauseLimit;
        end

        case (state_q)
            StHold: begin
                core_reset_d = 1'b1;
                running_d    = 1'b0;
                if (hold_q == HoldLast) begin
                    state_d      = StRun;
                    core_reset_d = 1'b0;
                    running_d    = 1'b1;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StRun: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                prev_pc_d    = pc;
                prev_valid_d = 1'b1;
                stall_d      = same_pc ? stall_q + StallW'(1) : '0;
                if (hit_cause != CauseNone) begin
                    state_d    = StDone;
                    done_d     = 1'b1;
                    running_d  = 1'b0;
                    cause_d    = hit_cause;
                    final_pc_d = pc;
                end
            end
            StDone: begin
                running_d    = 1'b0;
                core_reset_d = 1'b0;
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign halt_cause = cause_q;
    assign cycle_cnt  = cnt_q;
    assign final_pc   = final_pc_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: directed runs push the expected end-of-run record, and a
// monitor compares it when done rises.
module tb_sim_run_ctrl;

    localparam logic [31:0] HALT = 32'h0000_000C;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_reset;
    logic        running;
    logic        done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] final_pc;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    sim_run_ctrl #(
        .RESET_CYCLES (2),
        .MAX_CYCLES   (20),
        .STALL_LIMIT  (3),
        .HALT_EN      (1'b1),
        .HALT_INSTR   (HALT),
        .CNT_W        (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .final_pc   (final_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each rising edge of done, pop the expected record and compare.
    initial begin
        logic done_d;
        exp_t e;
        done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_d === 1'b0) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_done: got cause %0h pc %0h want no termination",
                             halt_cause, final_pc);
                end else begin
                    e = sb.pop_front();
                    check("sb_cause", 64'(halt_cause), 64'(e.cause));
                    check("sb_final_pc", 64'(final_pc), 64'(e.fpc));
                    check("sb_cycle_cnt", 64'(cycle_cnt), 64'(e.cnt));
                    check("sb_running", 64'(running), 64'd0);
                end
            end
            done_d = done;
        end
    end

    task automatic push_exp(input logic [1:0] cause, input logic [31:0] fpc,
                            input logic [31:0] cnt);
        exp_t e;
        e.cause = cause;
        e.fpc   = fpc;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    task automatic step(input logic [31:0] p, input logic [31:0] i);
        pc    = p;
        instr = i;
        @(posedge clk);
        #1;
    endtask

    // Reset for n posedges, then check the two-cycle stretch. Leaves the DUT in RUN with the
    // next step() supplying RUN cycle 1. A halt opcode is driven throughout to show it is ignored.
    task automatic start_run(input int n);
        reset = 1'b1;
        pc    = 32'hdead_beef;
        instr = HALT;
        repeat (n) @(posedge clk);
        #1;
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_running", 64'(running), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cause", 64'(halt_cause), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("rst_final_pc", 64'(final_pc), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("hold1_core_reset", 64'(core_reset), 64'd1);
        check("hold1_running", 64'(running), 64'd0);
        @(posedge clk);
        #1;
        check("hold2_core_reset", 64'(core_reset), 64'd0);
        check("hold2_running", 64'(running), 64'd1);
        check("hold2_done", 64'(done), 64'd0);
        check("hold2_cycle_cnt", 64'(cycle_cnt), 64'd0);
    endtask

    // Let the monitor see done, then require every pushed record to have been consumed.
    task automatic drain(input string name);
        step(32'h0, 32'h0);
        step(32'h0, 32'h0);
        check(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        pc    = '0;
        instr = '0;

        // Halt instruction at 0x3010 on the 5th RUN cycle.
        start_run(3);
        push_exp(2'b01, 32'h3010, 32'd5);
        for (int k = 0; k < 5; k++) step(32'h3000 + 32'(4 * k), (k == 4) ? HALT : 32'h0);
        drain("halt_drained");

        // Self-loop: third identical 0x3008 sample on RUN cycle 5.
        start_run(1);
        push_exp(2'b10, 32'h3008, 32'd5);
        step(32'h3000, 32'h0);
        step(32'h3004, 32'h0);
        step(32'h3008, 32'h0);
        step(32'h3008, 32'h0);
        check("loop_not_early", 64'(done), 64'd0);
        step(32'h3008, 32'h0);
        drain("loop_drained");

        // Pairs of identical PCs must not trip the self-loop; the run ends on the halt instead.
        start_run(1);
        push_exp(2'b01, 32'h300C, 32'd7);
        step(32'h3000, 32'h0);
        step(32'h3000, 32'h0);
        step(32'h3004, 32'h0);
        step(32'h3004, 32'h0);
        step(32'h3008, 32'h0);
        step(32'h3008, 32'h0);
        check("pairs_no_loop", 64'(done), 64'd0);
        check("pairs_running", 64'(running), 64'd1);
        step(32'h300C, HALT);
        drain("pairs_drained");

        // Timeout after 20 advancing cycles, then frozen for 10 more.
        start_run(1);
        push_exp(2'b11, 32'h304C, 32'd20);
        for (int k = 0; k < 20; k++) step(32'h3000 + 32'(4 * k), 32'h0);
        for (int k = 0; k < 10; k++) step(32'h5000 + 32'(8 * k), (k == 3) ? HALT : 32'h0);
        check("frozen_cycle_cnt", 64'(cycle_cnt), 64'd20);
        check("frozen_final_pc", 64'(final_pc), 64'h304C);
        check("frozen_cause", 64'(halt_cause), 64'd3);
        check("frozen_done", 64'(done), 64'd1);
        check("frozen_core_reset", 64'(core_reset), 64'd0);
        drain("timeout_drained");

        // Halt, self-loop and timeout all on RUN cycle 20: halt wins.
        start_run(1);
        push_exp(2'b01, 32'h3100, 32'd20);
        for (int k = 0; k < 17; k++) step(32'h3000 + 32'(4 * k), 32'h0);
        step(32'h3100, 32'h0);
        step(32'h3100, 32'h0);
        step(32'h3100, HALT);
        drain("simul_drained");

        // Reset mid-run at cycle_cnt 7, then a fresh run counting from 0.
        start_run(1);
        for (int k = 0; k < 7; k++) step(32'h4000 + 32'(4 * k), 32'h0);
        check("midrun_cnt7", 64'(cycle_cnt), 64'd7);
        start_run(1);
        push_exp(2'b01, 32'h600C, 32'd4);
        step(32'h6000, 32'h0);
        step(32'h6004, 32'h0);
        step(32'h6008, 32'h0);
        check("fresh_cnt3", 64'(cycle_cnt), 64'd3);
        step(32'h600C, HALT);
        drain("fresh_drained");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised run controller for the single-cycle MIPS simulation harness. It takes the raw clock and reset, generates a stretched core reset of configurable length, and counts executed cycles. It ends a run on a halt instruction, a self-loop (PC stable for N cycles) or a cycle-limit timeout, and reports the cause and the final PC. It sits between the bench clock/reset source and the `mips` top, replacing fixed `#delay` run windows with deterministic, cycle-exact termination.

## Interface
Parameters:
- `RESET_CYCLES`, 2: number of cycles `core_reset` is held after `reset` deasserts (≥1).
- `MAX_CYCLES`, 1000: number of RUN cycles before timeout (≥1).
- `STALL_LIMIT`, 4: number of consecutive identical PC samples that declares a self-loop halt (≥2).
- `HALT_EN`, 1: enables halt-instruction detection.
- `HALT_INSTR`, 32'h0000_000C: halt opcode pattern (`syscall`).
- `CNT_W`, 32: width of `cycle_cnt`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: current core PC.
- `instr` in 32: instruction currently fetched at `pc`.
- `core_reset` out 1: reset to the core, active-high.
- `running` out 1: high in RUN state.
- `done` out 1: sticky run-complete flag.
- `halt_cause` out 2: 00 none, 01 halt instr, 10 self-loop, 11 timeout.
- `cycle_cnt` out CNT_W: RUN cycles elapsed.
- `final_pc` out 32: PC sampled on the terminating cycle.

## Operation
- States: HOLD, RUN, DONE. All outputs are registered.
- Reset (`reset`=1 at posedge): state=HOLD, hold counter=0, `core_reset`=1, `running`=0, `done`=0, `halt_cause`=00, `cycle_cnt`=0, `final_pc`=0, stall counter=0, `prev_valid`=0.
- HOLD:
  - `core_reset`=1.
  - Hold counter increments each cycle `reset`=0.
  - When the counter reaches `RESET_CYCLES-1`, go to RUN. `core_reset` therefore stays high for exactly `RESET_CYCLES` cycles after `reset` falls.
- RUN:
  - `core_reset`=0, `running`=1.
  - Each cycle, `cycle_cnt` += 1, `prev_pc`←`pc`, `prev_valid`←1.
  - Stall counter: incremented when `prev_valid` && `pc`==`prev_pc`; cleared otherwise.
  - Termination checks on the current sample, in priority order:
    1. `HALT_EN` && `instr`==`HALT_INSTR` → cause 01.
    2. Stall counter == `STALL_LIMIT-2` && `pc`==`prev_pc` && `prev_valid`, i.e. the `STALL_LIMIT`-th identical sample → cause 10.
    3. `cycle_cnt`==`MAX_CYCLES-1` → cause 11.
  - On any hit: go to DONE, `done`←1, `halt_cause`←cause, `final_pc`←`pc`. `cycle_cnt` still increments on the terminating cycle.
- DONE:
  - `running`=0, `core_reset`=0.
  - `cycle_cnt`, `final_pc` and `halt_cause` are frozen. `done` stays high until `reset`.
- Arithmetic:
  - `cycle_cnt` saturates at all-ones and never wraps.
  - Compare against `MAX_CYCLES` is zero-extended to `CNT_W`.
- `reset` in any state, including mid-RUN or in DONE, returns the block to its reset values on the next posedge.

## Timing
- `core_reset` falls at the posedge ending the `RESET_CYCLES`-th HOLD cycle. The first RUN cycle is the first cycle the core executes.
- Termination latency: `done` and `halt_cause` assert one cycle after the qualifying `pc`/`instr` sample (registered).
- Simultaneous conditions resolve by the fixed priority halt > self-loop > timeout. Exactly one cause is latched.
- `instr` and `pc` are ignored outside RUN.

## Test plan
- Reset stretch, `RESET_CYCLES`=2: hold `reset` 1 for 3 cycles, release → `core_reset` high for exactly 2 further posedges; `running` rises on the 3rd; all outputs 0 during reset except `core_reset`=1.
- Halt instr: PC increments by 4 from 0x3000; `instr`=0x0000000C at PC 0x3010 → `done`=1 next cycle, cause 01, `final_pc`=0x3010, `cycle_cnt`=5.
- Self-loop, `STALL_LIMIT`=3: PC 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 → cause 10 on the 3rd 0x3008 sample (5th RUN cycle), `final_pc`=0x3008. Two repeats then a change must not trigger.
- Timeout, `MAX_CYCLES`=20, always-advancing PC → `done` after 20 RUN cycles, cause 11, `cycle_cnt`=20, frozen afterward for 10 more cycles.
- Simultaneous: halt instr on the `MAX_CYCLES`-th cycle while PC is stalled → cause 01.
- Mid-run reset: assert `reset` at `cycle_cnt`=7 → next cycle all outputs at reset values, state HOLD. A fresh run then repeats the stretch and counts from 0.
